// File: rtl/and4_bist_pkg.sv
// Shared types and constants for the 74x08 BIST sequencer.
package and4_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [7:0]  VEC_LAST   = 8'hFF;
  localparam int unsigned FAIL_CNT_W = 9;

endpackage

// File: rtl/and4_bist_timer.sv
// Settle timer: 4-bit down-counter loaded on SETTLE entry, one-cycle expire at zero.
module and4_bist_timer #(
  parameter logic [3:0] LOAD_VAL = 4'd1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  // Expire only while armed, so it pulses once per load.
  assign expire_o = run_q && (cnt_q == 4'd0);

  // Load takes priority; otherwise count down and disarm on reaching zero.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 4'd0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/and4_bist_ctrl.sv
// BIST sequencer: walks all 256 A/B vectors through a quad 2-input AND device,
// counts mismatches and captures the first failing vector.
module and4_bist_ctrl
  import and4_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned STOP_ON_FAIL  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [0:3]            A,
  output logic [0:3]            B,
  input  logic [0:3]            Y,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [FAIL_CNT_W-1:0] FAIL_CNT,
  output logic [7:0]            FAIL_VEC,
  output logic [0:3]            FAIL_Y
);

  localparam logic [3:0]            TIMER_LOAD   = 4'(SETTLE_CYCLES - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = FAIL_CNT_W'(256);

  state_e                state_q, state_d;
  logic [7:0]            vec_q, vec_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [7:0]            fail_vec_q, fail_vec_d;
  logic [0:3]            fail_y_q, fail_y_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timer_load, timer_expire;
  logic [0:3]            exp_y;
  logic                  mismatch;

  and4_bist_timer #(
    .LOAD_VAL(TIMER_LOAD)
  ) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (timer_load),
    .expire_o(timer_expire)
  );

  // Slice order maps VEC[7]/VEC[3] onto bit 0 (MSB) of A/B.
  assign A        = vec_q[7:4];
  assign B        = vec_q[3:0];
  assign exp_y    = vec_q[7:4] & vec_q[3:0];
  assign mismatch = (Y != exp_y);

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign FAIL_CNT = fail_cnt_q;
  assign FAIL_VEC = fail_vec_q;
  assign FAIL_Y   = fail_y_q;

  // Next-state, result update and timer load.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    fail_cnt_d = fail_cnt_q;
    fail_vec_d = fail_vec_q;
    fail_y_d   = fail_y_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          fail_cnt_d = '0;
          fail_vec_d = '0;
          fail_y_d   = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expire) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (fail_cnt_q != FAIL_CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) begin
            fail_vec_d = vec_q;
            fail_y_d   = Y;
          end
        end
        if ((vec_q == VEC_LAST) || ((STOP_ON_FAIL != 0) && mismatch)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d    = ST_SETTLE;
          vec_d      = vec_q + 8'd1;
          timer_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      fail_cnt_q <= '0;
      fail_vec_q <= '0;
      fail_y_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      fail_cnt_q <= fail_cnt_d;
      fail_vec_q <= fail_vec_d;
      fail_y_q   <= fail_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

endmodule

// File: tb/tb_and4_bist_ctrl.sv
// Bench for and4_bist_ctrl: two instances (run-to-end and stop-on-fail),
// each beside a 74x08 model with an optional Y[2] stuck-at-0 fault.
module tb_and4_bist_ctrl;

  localparam logic [0:3] STUCK_MASK = 4'b1101;

  typedef struct {
    int unsigned cycles;
    int unsigned cnt;
    logic [7:0]  fv;
    logic [0:3]  fy;
    logic        pass;
    logic [7:0]  last;
  } exp_t;

  exp_t sbq[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic sel = 1'b0;
  logic fault0 = 1'b0;
  logic fault1 = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic       start0, start1;
  logic [0:3] a0, b0, y0, fy0, a1, b1, y1, fy1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] cnt0, cnt1;
  logic [7:0] fvec0, fvec1;

  logic [0:3] a_s, b_s, fy_s;
  logic       busy_s, done_s, pass_s;
  logic [8:0] cnt_s;
  logic [7:0] fvec_s;

  always #5 clk = ~clk;

  assign start0 = go && !sel;
  assign start1 = go && sel;

  // 74x08 device models with optional stuck-at fault on Y[2].
  assign y0 = (a0 & b0) & (fault0 ? STUCK_MASK : 4'b1111);
  assign y1 = (a1 & b1) & (fault1 ? STUCK_MASK : 4'b1111);

  assign a_s    = sel ? a1 : a0;
  assign b_s    = sel ? b1 : b0;
  assign fy_s   = sel ? fy1 : fy0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign pass_s = sel ? pass1 : pass0;
  assign cnt_s  = sel ? cnt1 : cnt0;
  assign fvec_s = sel ? fvec1 : fvec0;

  and4_bist_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start0), .A(a0), .B(b0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_CNT(cnt0),
    .FAIL_VEC(fvec0), .FAIL_Y(fy0)
  );

  and4_bist_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_CNT(cnt1),
    .FAIL_VEC(fvec1), .FAIL_Y(fy1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Predict a run, launch it, and compare results when DONE rises.
  task automatic run_check(input logic s, input logic flt, input logic pulses);
    exp_t        e;
    logic [7:0]  vb;
    logic [0:3]  ea, eb, ey, gy;
    int unsigned n;
    bit          first;
    e.cycles = 768; e.cnt = 0; e.fv = '0; e.fy = '0; e.last = 8'hFF; first = 1'b1;
    for (int v = 0; v < 256; v++) begin
      vb = 8'(v);
      ea = vb[7:4];
      eb = vb[3:0];
      ey = ea & eb;
      gy = flt ? (ey & STUCK_MASK) : ey;
      if (gy != ey) begin
        e.cnt++;
        if (first) begin
          e.fv  = vb;
          e.fy  = gy;
          first = 1'b0;
        end
        if (s) begin
          e.cycles = 3 * (v + 1);
          e.last   = vb;
          break;
        end
      end
    end
    e.pass = (e.cnt == 0);

    sel = s;
    if (s) fault1 = flt; else fault0 = flt;
    @(negedge clk);
    go = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1 go = 1'b0;
    check_val("start_busy", 32'(busy_s), 32'd1);
    check_val("start_ab",   32'({a_s, b_s}), 32'h00);
    check_val("start_done", 32'(done_s), 32'd0);
    check_val("start_cnt",  32'(cnt_s), 32'd0);
    check_val("start_fvec", 32'(fvec_s), 32'd0);

    n = 0;
    while (!done_s && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      go = pulses && (n == 10 || n == 400);
      if (n == 469 && e.cycles == 768) check_val("mid_ab", 32'({a_s, b_s}), 32'h9C);
    end
    go = 1'b0;

    e = sbq.pop_front();
    check_val("done_cycle", n, e.cycles);
    check_val("done_flag",  32'(done_s), 32'd1);
    check_val("done_busy",  32'(busy_s), 32'd0);
    check_val("done_pass",  32'(pass_s), 32'(e.pass));
    check_val("fail_cnt",   32'(cnt_s), e.cnt);
    check_val("fail_vec",   32'(fvec_s), 32'(e.fv));
    check_val("fail_y",     32'(fy_s), 32'(e.fy));
    check_val("final_ab",   32'({a_s, b_s}), 32'(e.last));
    repeat (3) @(posedge clk);
    #1;
    check_val("done_hold",  32'(done_s), 32'd1);
    check_val("hold_ab",    32'({a_s, b_s}), 32'(e.last));
  endtask

  initial begin
    #2;
    check_val("rst_ab",    32'({a0, b0}), 32'h00);
    check_val("rst_busy",  32'(busy0), 32'd0);
    check_val("rst_done",  32'(done0), 32'd0);
    check_val("rst_pass",  32'(pass0), 32'd0);
    check_val("rst_cnt",   32'(cnt0), 32'd0);
    check_val("rst_fvec",  32'(fvec0), 32'd0);
    check_val("rst_fy",    32'(fy0), 32'd0);
    check_val("rst_busy1", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_check(1'b0, 1'b0, 1'b1);  // clean run with START pulses while busy
    run_check(1'b0, 1'b1, 1'b0);  // stuck-at fault, full run
    run_check(1'b0, 1'b0, 1'b0);  // restart from DONE with the fault removed
    run_check(1'b1, 1'b1, 1'b0);  // stop on first failure

    // Asynchronous reset in the middle of a faulty run.
    sel = 1'b0;
    fault0 = 1'b1;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    check_val("pre_rst_cnt_nz", 32'(cnt0 != 9'd0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_ab",   32'({a0, b0}), 32'h00);
    check_val("arst_busy", 32'(busy0), 32'd0);
    check_val("arst_cnt",  32'(cnt0), 32'd0);
    check_val("arst_fvec", 32'(fvec0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_check(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
